// File: rtl/fir_pkg.sv
// Shared types and helpers for the tap_reader history buffer.
package fir_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        BURST
    } state_t;

    // Bits needed to address 'value' entries; returns at least 1.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/tap_ram.sv
// History buffer for tap_reader: one synchronous write port, one asynchronous read port.
module tap_ram
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset so it can map onto plain RAM/LUT-RAM; zeroing is the optional CLEAR sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tap_reader.sv
// Accepts one sample, then streams the TAPS most recent samples newest first.
// Define TAP_READER_CLEAR_EN to zero the history buffer after every reset.
module tap_reader
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int TAPS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(TAPS - 1);
`ifdef TAP_READER_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "tap_reader: DEPTH must be a power of two >= 2");
    end
    if (TAPS < 1 || TAPS > DEPTH) begin : g_bad_taps
        $fatal(1, "tap_reader: TAPS must be in 1..DEPTH");
    end

    state_t           state_q,   state_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
    logic             ram_we;
    logic [WIDTH-1:0] ram_wdata;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tap_cnt_q <= tap_cnt_d;
        end
    end

    // Handshake outputs are masked by rst so they drop the instant reset asserts, even from IDLE.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == BURST) && !rst;
    assign out_last  = out_valid && (tap_cnt_q == TAP_LAST);
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tap_cnt_d = tap_cnt_q;
        ram_we    = 1'b0;
        ram_wdata = in;

        unique case (state_q)
`ifdef TAP_READER_CLEAR_EN
            CLEAR: begin
                // wr_ptr doubles as the sweep address and wraps back to 0 when done.
                ram_we    = 1'b1;
                ram_wdata = '0;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                if (wr_ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                end
            end
`endif
            IDLE: begin
                if (accept) begin
                    ram_we    = 1'b1;
                    rd_ptr_d  = wr_ptr_q;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    tap_cnt_d = '0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (out_ready) begin
                    rd_ptr_d  = rd_ptr_q - 1'b1;
                    tap_cnt_d = tap_cnt_q + 1'b1;
                    if (tap_cnt_q == TAP_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    tap_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tap_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (out)
    );

endmodule

// File: doc/tap_reader.md
TAP_READER -- requirements
Module: tap_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: history-buffer entries, a power of two, >= 2.
REQ-003 SHALL have parameter TAPS, default 16: samples read per burst, 1..DEPTH; other values are an elaboration-time fatal error.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  new sample offered.
REQ-007 SHALL have port in  input  WIDTH  sample data.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-009 SHALL have port out_valid  output  1  tap word presented.
REQ-010 SHALL have port out  output  WIDTH  tap data, newest first.
REQ-011 SHALL have port out_last  output  1  marks tap TAPS-1 of a burst.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.

Function
REQ-013 SHALL store samples in a DEPTH-entry circular buffer with write pointer wr_ptr, wrapping DEPTH-1 -> 0.
REQ-014 SHALL implement states CLEAR (CLEAR_EN only), IDLE and BURST.
REQ-015 SHALL assert in_ready only in IDLE, with out_valid low in IDLE.
REQ-016 On an IDLE accept, SHALL write in to mem[wr_ptr], load rd_ptr <= wr_ptr, increment wr_ptr, clear tap count and enter BURST on the next cycle.
REQ-017 In BURST, SHALL hold out_valid high and drive out = mem[rd_ptr], so the first word is the sample just accepted (1-cycle latency from accept).
REQ-018 On each BURST output handshake, SHALL decrement rd_ptr modulo DEPTH and increment the tap count.
REQ-019 With out_ready low, SHALL hold out, out_last and rd_ptr stable.
REQ-020 SHALL assert out_last exactly when the tap count equals TAPS-1.
REQ-021 On the handshake with out_last high, SHALL return to IDLE, with in_ready high in the following cycle.
REQ-022 With TAPS = DEPTH, SHALL read the oldest sample at rd_ptr = wr_ptr (wrapped) without corruption.
REQ-023 SHALL never write the buffer during BURST, since in_ready is low.

Reset
REQ-024 While rst is high, SHALL force wr_ptr = 0, rd_ptr = 0, tap count = 0, out_valid = 0, out_last = 0 and in_ready = 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst immediately and emit no further words.
REQ-026 After reset release, SHALL enter CLEAR when CLEAR_EN is defined, otherwise IDLE.
REQ-027 Reset SHALL NOT require clearing the buffer contents unless CLEAR_EN is defined.

Configuration
REQ-028 Macro TAP_READER_CLEAR_EN defined: CLEAR state writes zero to entries 0..DEPTH-1, one per cycle, over DEPTH cycles with in_ready low, then enters IDLE, so unfilled taps read as 0.
REQ-029 Macro TAP_READER_CLEAR_EN undefined: no CLEAR state, and taps older than the number of samples written since reset are undefined.

Structure
REQ-030 SHALL place the state enumeration (CLEAR, IDLE, BURST) and the pointer-width function clog2(DEPTH) in shared package fir_pkg.
REQ-031 SHALL implement the buffer as sub-module tap_ram: one write port, one asynchronous read port, no reset on storage.
REQ-032 SHALL implement the FSM, pointers and counters in tap_reader itself.

Verification
REQ-033 Covered: CLEAR_EN, DEPTH=TAPS=4, reset release -> in_ready low for exactly 4 cycles; then push 5 -> burst out 5,0,0,0 with out_last on the 4th word.
REQ-034 Covered: push 1..6 with out_ready held high -> bursts after sample 6 reads 6,5,4,3, proving wrap-around.
REQ-035 Covered: out_ready toggled 1,0,0,1 per cycle -> out stable while stalled, no word lost or repeated, in_ready low throughout the burst.
REQ-036 Covered: TAPS=1 -> each accepted sample yields one word with out_last high, and in_ready returns 2 cycles after accept.
REQ-037 Covered: rst pulsed during the 2nd burst word -> out_valid low the same cycle, then wr_ptr=0 and the next push writes entry 0.
REQ-038 Covered: in_valid held high continuously -> exactly one accept per burst, with no buffer write while in_ready is low.
